// File: rtl/ub_pkg.sv
// rtl/ub_pkg.sv - shared types, error bit positions and address helper for the unified buffer
//
// Purpose : FSM state type, sticky error bit indices, and a modulo adder used
//           for every wrapped word address.
// Ports   : none (package)

package ub_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } ub_state_t;

   localparam int ERR_WR_OOR = 0;
   localparam int ERR_RD_OOR = 1;
   localparam int ERR_BUSY   = 2;

   // (a + b) mod depth, evaluated in 32 bits so DEPTH need not be a power of two.
   function automatic int unsigned wrap_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned depth);
      return (a + b) % depth;
   endfunction

endpackage

// File: rtl/ub_row_mem.sv
// rtl/ub_row_mem.sv - DEPTH-word storage with one N-word row port
//
// Purpose : word array accessed a row (N consecutive words) at a time.
//           Word addresses wrap modulo DEPTH. Read is combinational, write is
//           on the rising clock edge. Contents clear on reset.
// Ports   : clk    - clock
//           reset  - asynchronous active-low clear of all words
//           we     - write the row at addr this edge
//           addr   - word address of row word 0 (read and write share it)
//           wdata  - row to write, word k at [k*DATA_W +: DATA_W]
//           rdata  - row currently at addr, same packing

module ub_row_mem
   import ub_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N      = 2,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [N*DATA_W-1:0] wdata,
   output logic [N*DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] idx [N];

   always_comb begin
      for (int k = 0; k < N; k++) begin
         idx[k] = ADDR_W'(wrap_add(32'(addr), k, DEPTH));
      end
   end

   always_comb begin
      rdata = '0;
      for (int k = 0; k < N; k++) begin
         rdata[k*DATA_W +: DATA_W] = mem[idx[k]];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int k = 0; k < N; k++) begin
            mem[idx[k]] <= wdata[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/unified_buffer_burst.sv
// rtl/unified_buffer_burst.sv - row buffer with write handshake and multi-row read bursts
//
// Purpose : stores rows written by the accumulator bank and streams tiles of
//           rd_len rows to input_setup. Single-ported: a read burst blocks writes.
// Ports   : clk, reset (async active-low)
//           wr_valid/wr_ready/wr_addr/wr_data - write beat handshake, one row per beat
//           rd_start/rd_addr/rd_len          - burst request, sampled in IDLE
//           rd_busy/rd_valid/rd_data/rd_last - burst output, one row per cycle
//           wr_ptr                           - address following the last accepted row
//           err/err_clr                      - sticky error flags and their clear

module unified_buffer_burst
   import ub_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N      = 2,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int LEN_W  = 4,
   parameter int WRAP   = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [N*DATA_W-1:0] wr_data,
   input  logic                rd_start,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [LEN_W-1:0]    rd_len,
   output logic                rd_busy,
   output logic                rd_valid,
   output logic [N*DATA_W-1:0] rd_data,
   output logic                rd_last,
   output logic [ADDR_W-1:0]   wr_ptr,
   output logic [2:0]          err,
   input  logic                err_clr
);

   // Wide enough for rd_addr + rd_len*N without overflow.
   localparam int SUM_W = ADDR_W + LEN_W + 1;

   ub_state_t           state;
   logic [LEN_W-1:0]    rows_left;
   logic [ADDR_W-1:0]   cur_addr;
   logic [ADDR_W-1:0]   mem_addr;
   logic [N*DATA_W-1:0] mem_rdata;
   logic [SUM_W-1:0]    wr_end;
   logic [SUM_W-1:0]    rd_end;
   logic                wr_fire;
   logic                wr_ok;
   logic                rd_ok;
   logic                start_req;
   logic                start_ok;
   logic                mem_we;
   logic [2:0]          err_set;

   // A pending rd_start takes the port, so the write source must hold its beat.
   assign wr_ready  = (state == IDLE) && !rd_start;
   assign wr_fire   = wr_valid && wr_ready;

   assign wr_end    = SUM_W'(wr_addr) + SUM_W'(N);
   assign rd_end    = SUM_W'(rd_addr) + SUM_W'(rd_len) * SUM_W'(N);
   assign wr_ok     = (WRAP != 0) || (wr_end <= SUM_W'(DEPTH));
   assign rd_ok     = (WRAP != 0) || (rd_end <= SUM_W'(DEPTH));

   assign start_req = (state == IDLE) && rd_start && (rd_len != '0);
   assign start_ok  = start_req && rd_ok;
   // Out-of-range beats are still handshaken but never reach the array.
   assign mem_we    = wr_fire && wr_ok;

   // Row 0 is fetched on the start edge, later rows from cur_addr.
   assign mem_addr  = (state == READ) ? cur_addr : (rd_start ? rd_addr : wr_addr);

   always_comb begin
      err_set             = '0;
      err_set[ERR_WR_OOR] = wr_fire && !wr_ok;
      err_set[ERR_RD_OOR] = start_req && !rd_ok;
      err_set[ERR_BUSY]   = (state == READ) && rd_start;
   end

   ub_row_mem #(
      .DATA_W (DATA_W),
      .N      (N),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (wr_data),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rows_left <= '0;
         cur_addr  <= '0;
         rd_busy   <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
         wr_ptr    <= '0;
         err       <= '0;
      end else begin
         // Clear applies first so a simultaneous new error survives.
         err <= (err_clr ? 3'b000 : err) | err_set;

         if (mem_we) begin
            wr_ptr <= ADDR_W'(wrap_add(32'(wr_addr), N, DEPTH));
         end

         case (state)
            IDLE: begin
               if (start_ok) begin
                  state     <= READ;
                  rd_busy   <= 1'b1;
                  rd_valid  <= 1'b1;
                  rd_data   <= mem_rdata;
                  rd_last   <= (rd_len == LEN_W'(1));
                  rows_left <= rd_len - LEN_W'(1);
                  cur_addr  <= ADDR_W'(wrap_add(32'(rd_addr), N, DEPTH));
               end
            end
            READ: begin
               // rows_left counts rows still to fetch after the one on rd_data.
               if (rows_left == '0) begin
                  state    <= IDLE;
                  rd_busy  <= 1'b0;
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
               end else begin
                  rd_data   <= mem_rdata;
                  rd_last   <= (rows_left == LEN_W'(1));
                  rows_left <= rows_left - LEN_W'(1);
                  cur_addr  <= ADDR_W'(wrap_add(32'(cur_addr), N, DEPTH));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_buffer_burst.sv
// tb/tb_unified_buffer_burst.sv - directed scoreboard bench for unified_buffer_burst

module tb_unified_buffer_burst;

   localparam int DW  = 8;
   localparam int NW  = 2;
   localparam int DEP = 16;
   localparam int AW  = 4;
   localparam int LW  = 4;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } row_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          sel;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          rd_start;
   logic [AW-1:0] rd_addr;
   logic [LW-1:0] rd_len;
   logic          err_clr;

   logic          a_wr_ready, a_rd_busy, a_rd_valid, a_rd_last;
   logic [15:0]   a_rd_data;
   logic [AW-1:0] a_wr_ptr;
   logic [2:0]    a_err;
   logic          b_wr_ready, b_rd_busy, b_rd_valid, b_rd_last;
   logic [15:0]   b_rd_data;
   logic [AW-1:0] b_wr_ptr;
   logic [2:0]    b_err;

   logic          wr_ready, rd_busy, rd_valid, rd_last;
   logic [15:0]   rd_data;
   logic [AW-1:0] wr_ptr;
   logic [2:0]    err;

   // sel=0 drives the WRAP=0 instance, sel=1 the WRAP=1 instance.
   unified_buffer_burst #(.DATA_W(DW), .N(NW), .DEPTH(DEP), .LEN_W(LW), .WRAP(0)) dut_a (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid && !sel), .wr_ready(a_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_start(rd_start && !sel), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_busy(a_rd_busy), .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_last(a_rd_last),
      .wr_ptr(a_wr_ptr), .err(a_err), .err_clr(err_clr && !sel)
   );

   unified_buffer_burst #(.DATA_W(DW), .N(NW), .DEPTH(DEP), .LEN_W(LW), .WRAP(1)) dut_b (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid && sel), .wr_ready(b_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_start(rd_start && sel), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_busy(b_rd_busy), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_last(b_rd_last),
      .wr_ptr(b_wr_ptr), .err(b_err), .err_clr(err_clr && sel)
   );

   assign wr_ready = sel ? b_wr_ready : a_wr_ready;
   assign rd_busy  = sel ? b_rd_busy  : a_rd_busy;
   assign rd_valid = sel ? b_rd_valid : a_rd_valid;
   assign rd_last  = sel ? b_rd_last  : a_rd_last;
   assign rd_data  = sel ? b_rd_data  : a_rd_data;
   assign wr_ptr   = sel ? b_wr_ptr   : a_wr_ptr;
   assign err      = sel ? b_err      : a_err;

   int   checks   = 0;
   int   failures = 0;
   row_t exp_q[$];
   logic [7:0] mdl [2][16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mdl_row(input int s, input int addr);
      return {mdl[s][(addr + 1) % 16], mdl[s][addr % 16]};
   endfunction

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 16; i++)
            mdl[s][i] = 8'h00;
   endtask

   // One clock; any row the DUT presents is popped from the scoreboard.
   task automatic tick();
      @(posedge clk);
      #2;
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
         end else begin
            row_t e;
            e = exp_q.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e.data));
            chk("rd_last", 32'(rd_last), 32'(e.last));
            chk("rd_busy_in_burst", 32'(rd_busy), 32'd1);
         end
      end
   endtask

   task automatic push_burst(input int addr, input int len);
      row_t e;
      for (int k = 0; k < len; k++) begin
         e.data = mdl_row(int'(sel), addr + k * NW);
         e.last = (k == len - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic write_beat(input int addr, input logic [15:0] data, input bit ok);
      wr_valid = 1'b1;
      wr_addr  = AW'(addr);
      wr_data  = data;
      #1;
      chk("wr_ready_idle", 32'(wr_ready), 32'd1);
      tick();
      wr_valid = 1'b0;
      if (ok) begin
         mdl[int'(sel)][addr % 16]       = data[7:0];
         mdl[int'(sel)][(addr + 1) % 16] = data[15:8];
      end
   endtask

   task automatic burst(input int addr, input int len);
      push_burst(addr, len);
      rd_start = 1'b1;
      rd_addr  = AW'(addr);
      rd_len   = LW'(len);
      tick();
      rd_start = 1'b0;
      repeat (len - 1) tick();
      tick();
      chk("burst_end_valid", 32'(rd_valid), 32'd0);
      chk("burst_end_busy", 32'(rd_busy), 32'd0);
      chk("burst_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      sel = 1'b0; reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      rd_start = 1'b0; rd_addr = '0; rd_len = '0; err_clr = 1'b0;
      clear_model();

      // Reset state
      repeat (2) tick();
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_busy", 32'(rd_busy), 32'd0);
      chk("rst_rd_last", 32'(rd_last), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      reset = 1'b1;
      tick();

      // Basic writes then a two-row burst
      write_beat(0, 16'h0201, 1'b1);
      write_beat(2, 16'h0403, 1'b1);
      chk("t1_wr_ptr", 32'(wr_ptr), 32'd4);
      burst(0, 2);

      // Write held across a burst: stalled 4 cycles, lands after rd_last
      wr_valid = 1'b1; wr_addr = 4'd6; wr_data = 16'h0605;
      rd_start = 1'b1; rd_addr = 4'd0; rd_len = 4'd3;
      push_burst(0, 3);
      #1 chk("t2_wr_ready_T0", 32'(wr_ready), 32'd0);
      tick();
      rd_start = 1'b0;
      #1 chk("t2_wr_ready_T1", 32'(wr_ready), 32'd0);
      tick();
      #1 chk("t2_wr_ready_T2", 32'(wr_ready), 32'd0);
      tick();
      #1 chk("t2_wr_ready_T3", 32'(wr_ready), 32'd0);
      tick();
      #1 chk("t2_wr_ready_T4", 32'(wr_ready), 32'd1);
      chk("t2_wr_ptr_stalled", 32'(wr_ptr), 32'd4);
      tick();
      wr_valid = 1'b0;
      mdl[0][6] = 8'h05; mdl[0][7] = 8'h06;
      chk("t2_wr_ptr", 32'(wr_ptr), 32'd8);
      chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
      burst(6, 1);

      // Range errors (WRAP=0)
      write_beat(14, 16'h2211, 1'b1);
      chk("t3_wr_ptr_top", 32'(wr_ptr), 32'd0);
      chk("t3_err_none", 32'(err), 32'd0);
      write_beat(15, 16'hEEEE, 1'b0);
      chk("t3_err_wr", 32'(err), 32'd1);
      chk("t3_wr_ptr_kept", 32'(wr_ptr), 32'd0);
      rd_start = 1'b1; rd_addr = 4'd12; rd_len = 4'd3;
      tick();
      rd_start = 1'b0;
      chk("t3_rej_valid", 32'(rd_valid), 32'd0);
      chk("t3_rej_busy", 32'(rd_busy), 32'd0);
      chk("t3_err_rd", 32'(err), 32'd3);
      tick();
      chk("t3_rej_valid2", 32'(rd_valid), 32'd0);
      burst(14, 1);
      burst(10, 3);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t3_err_clr", 32'(err), 32'd0);
      err_clr = 1'b1; wr_valid = 1'b1; wr_addr = 4'd15;
      tick();
      err_clr = 1'b0; wr_valid = 1'b0;
      chk("t3_set_wins", 32'(err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t3_err_clr2", 32'(err), 32'd0);
      rd_start = 1'b1; rd_addr = 4'd0; rd_len = 4'd0;
      tick();
      rd_start = 1'b0;
      chk("t3_len0_valid", 32'(rd_valid), 32'd0);
      chk("t3_len0_err", 32'(err), 32'd0);

      // rd_start while busy and on the rd_last cycle
      push_burst(0, 3);
      rd_start = 1'b1; rd_addr = 4'd0; rd_len = 4'd3;
      tick();
      rd_addr = 4'd2; rd_len = 4'd1;
      tick();
      rd_start = 1'b0;
      chk("t5_err_busy", 32'(err), 32'd4);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t5_err_cleared", 32'(err), 32'd0);
      chk("t5_on_last", 32'(rd_last), 32'd1);
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      chk("t5_err_last", 32'(err), 32'd4);
      chk("t5_ignored_valid", 32'(rd_valid), 32'd0);
      chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      burst(2, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // WRAP=1 instance
      sel = 1'b1;
      #1;
      chk("t4_err_init", 32'(err), 32'd0);
      write_beat(15, 16'hBBAA, 1'b1);
      chk("t4_wr_ptr", 32'(wr_ptr), 32'd1);
      chk("t4_err", 32'(err), 32'd0);
      exp_q.push_back('{data: 16'hAA00, last: 1'b0});
      exp_q.push_back('{data: 16'h00BB, last: 1'b1});
      rd_start = 1'b1; rd_addr = 4'd14; rd_len = 4'd2;
      tick();
      rd_start = 1'b0;
      tick();
      tick();
      chk("t4_drained", 32'(exp_q.size()), 32'd0);
      burst(14, 3);
      chk("t4_err_after", 32'(err), 32'd0);
      sel = 1'b0;

      // Reset mid-burst
      push_burst(0, 4);
      rd_start = 1'b1; rd_addr = 4'd0; rd_len = 4'd4;
      tick();
      rd_start = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk("t6_valid_drop", 32'(rd_valid), 32'd0);
      chk("t6_busy_drop", 32'(rd_busy), 32'd0);
      chk("t6_last_drop", 32'(rd_last), 32'd0);
      exp_q.delete();
      clear_model();
      tick();
      reset = 1'b1;
      chk("t6_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      tick();
      burst(0, 8);
      burst(5, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unified_buffer_burst.md
Name: unified_buffer_burst

Overview:
Parametrised successor to the 2x2 unified buffer. Stores rows of N words (DATA_W bits each) written by the accumulator bank, and streams multi-row tiles to the input-setup stage as read bursts. Adds a write valid/ready handshake, a burst-read FSM, an optional address wrap mode, and sticky error reporting. It sits between the accumulators and input_setup.

Parameters:
DATA_W, 8, bits per word
N, 2, words per row/beat (systolic array width)
DEPTH, 64, total words of storage; must be a multiple of N
ADDR_W, $clog2(DEPTH), word address width
LEN_W, 4, width of the burst row count
WRAP, 0, 1 = burst/write addresses wrap modulo DEPTH; 0 = out-of-range is an error

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-low (0 = reset asserted)
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted this cycle
wr_addr  in  ADDR_W  word address of the beat's word 0
wr_data  in  N*DATA_W  word k at bits [k*DATA_W +: DATA_W]
rd_start  in  1  request a read burst (sampled in IDLE only)
rd_addr  in  ADDR_W  word address of row 0
rd_len  in  LEN_W  number of rows in the burst
rd_busy  out  1  burst in progress
rd_valid  out  1  rd_data holds a valid row
rd_data  out  N*DATA_W  row data, same packing as wr_data
rd_last  out  1  final row of the burst
wr_ptr  out  ADDR_W  next free address = last accepted wr_addr+N (mod DEPTH)
err  out  3  sticky: [0] write out of range, [1] read out of range, [2] rd_start while busy
err_clr  in  1  clears err

Behaviour:
- Reset (reset=0, asynchronous): memory = 0; rd_data/rd_valid/rd_last/rd_busy = 0; wr_ptr = 0; err = 0; FSM = IDLE. Reset asserted during a burst aborts it immediately.
- Storage is single-ported: one access (one row read or one row write) per cycle.
- FSM states: IDLE, READ.
- IDLE -> READ on rd_start && rd_len != 0 && range OK. Loads row counter = rd_len and current address = rd_addr.
- READ -> IDLE on the edge after the beat with rd_last.
- Handshake: wr_ready = (state==IDLE) && !rd_start (combinational). A beat is accepted when wr_valid && wr_ready. Reads win over writes. A stalled beat must be held by the source.
- Accepted write: words addr..addr+N-1 are written at the clock edge; wr_ptr is updated at the same edge.
- Write range: if WRAP=0 and wr_addr+N > DEPTH, the beat is accepted (wr_ready honoured) but dropped, err[0] is set, and wr_ptr is unchanged. If WRAP=1, addresses wrap modulo DEPTH.
- Read timing: rd_start in cycle T sets rd_busy=1 and rd_valid=1 during T+1..T+len. Row k appears in cycle T+1+k and is read from words rd_addr+k*N .. +N-1. rd_last=1 in cycle T+len only. No consumer backpressure.
- Read range: if WRAP=0 and rd_addr + rd_len*N > DEPTH, the burst is rejected (stays IDLE, no rd_valid) and err[1] is set. If WRAP=1, addresses wrap.
- rd_len == 0: no-op, no error.
- rd_start while rd_busy (including the rd_last cycle) is ignored and sets err[2]. A new start is accepted from cycle T+len+1.
- Outside a burst, rd_valid = rd_last = 0 and rd_data holds its last value.
- err bits are sticky. err_clr clears them at the next edge. If a set and err_clr occur in the same cycle, the set wins.
- Arithmetic: address math is done in ADDR_W+LEN_W+1 bits to detect overflow before the wrap or error decision.

Decomposition:
- Package ub_pkg: typedef enum {IDLE, READ} ub_state_t; localparams ERR_WR_OOR=0, ERR_RD_OOR=1, ERR_BUSY=2.
- One sub-module, ub_row_mem: a DEPTH-word array with an N-word row read/write port, addresses wrapped modulo DEPTH internally, and asynchronous active-low clear.
- FSM, handshake and error logic stay in unified_buffer_burst.

Test Plan (DATA_W=8, N=2, DEPTH=16, WRAP=0 unless noted):
1. Reset, then write 0x0201 at addr 0 and 0x0403 at addr 2; burst rd_addr=0, len=2 -> rows 0x0201, 0x0403 on the two cycles after start; rd_last on row 2; wr_ptr=4.
2. rd_start with wr_valid in the same cycle, and wr_valid held through the burst (len=3) -> wr_ready=0 for 4 cycles; write lands the cycle after rd_last; no data lost.
3. Write at addr 15 -> err=3'b001, memory and wr_ptr unchanged. Burst addr 12, len 3 -> no rd_valid, err=3'b011. err_clr -> 0.
4. WRAP=1: write 0xBBAA at addr 15 -> word15=0xAA, word0=0xBB. Burst addr 14, len 2 -> row 2 returns {word1, word0}.
5. rd_start during an active burst and on the rd_last cycle -> ignored, err[2]=1; a start one cycle later is accepted.
6. reset=0 mid-burst (row 2 of 4) -> rd_valid/rd_busy drop immediately; after release, a read of any address returns 0.
